// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider.
//   DIV_WIDTH_DEFAULT : default operand/quotient/remainder width
//   div_state_t       : controller state encoding (IDLE, CALC, DONE)
package div_pkg;

  localparam int unsigned DIV_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div4_seq_if.sv
// Request/result bundle of the sequential divider.
//   master : drives start/dividend/divisor, observes busy/done/results
//   slave  : the divider side
interface div4_seq_if
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) ();

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_zero
  );

endinterface

// File: rtl/div_sub_stage.sv
// Trial subtract of one restoring-division step, purely combinational.
//   t    : WIDTH+1-bit trial value {R[WIDTH-1:0], Q msb}
//   d    : divisor
//   diff : t - d (meaningful when ge=1)
//   ge   : carry-out of the ripple, i.e. t >= d
module div_sub_stage #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH:0]   t,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   diff,
  output logic             ge
);

  localparam int unsigned N = WIDTH + 1;

  logic [N-1:0] b_inv;

  assign b_inv = ~{1'b0, d};

  // Ripple of full-adder cells: t + ~d + 1; carry-out high means no borrow.
  always_comb begin
    logic carry;
    diff  = '0;
    carry = 1'b1;
    for (int i = 0; i < int'(N); i++) begin
      diff[i] = t[i] ^ b_inv[i] ^ carry;
      carry   = (t[i] & b_inv[i]) | (carry & (t[i] ^ b_inv[i]));
    end
    ge = carry;
  end

endmodule

// File: rtl/div4_seq.sv
// Sequential restoring divider, one quotient bit per CALC cycle.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : div4_seq_if slave (start/dividend/divisor in;
//              busy/done/quotient/remainder/div_zero out)
// Optional build macro DIV4_SEQ_ZERO_CHECK_EN: a zero divisor skips the
// iterations, completes in one cycle and raises div_zero.
module div4_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  div4_seq_if.slave  bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_t       state_q;
  logic [WIDTH:0]   r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;

  logic [WIDTH:0]   t;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH:0]   r_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             last_iter;

  // One restoring step on the current partial remainder / quotient pair.
  assign t         = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign r_nxt     = ge ? diff : t;
  assign q_nxt     = WIDTH'({q_q, ge});
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  div_sub_stage #(.WIDTH(WIDTH)) u_sub (
    .t    (t),
    .d    (d_q),
    .diff (diff),
    .ge   (ge)
  );

  // R's top bit is always 0 after a restoring step and never feeds the next one.
  logic unused_r_msb;
  assign unused_r_msb = r_q[WIDTH];

`ifdef DIV4_SEQ_ZERO_CHECK_EN
  logic div_zero_q;
  assign bus.div_zero = div_zero_q;
`else
  assign bus.div_zero = 1'b0;
`endif

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;

  // Controller, datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
`ifdef DIV4_SEQ_ZERO_CHECK_EN
      div_zero_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            r_q   <= '0;
            q_q   <= bus.dividend;
            d_q   <= bus.divisor;
            cnt_q <= '0;
`ifdef DIV4_SEQ_ZERO_CHECK_EN
            if (bus.divisor == '0) begin
              state_q    <= DONE;
              done_q     <= 1'b1;
              div_zero_q <= 1'b1;
              quot_q     <= '1;
              rem_q      <= bus.dividend;
            end else begin
              state_q    <= CALC;
              busy_q     <= 1'b1;
              div_zero_q <= 1'b0;
            end
`else
            state_q <= CALC;
            busy_q  <= 1'b1;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          r_q   <= r_nxt;
          q_q   <= q_nxt;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_iter) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            quot_q  <= q_nxt;
            rem_q   <= r_nxt[WIDTH-1:0];
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
